// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle combinational multiply).
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MULH  = 3'b001,
    OP_MULHU = 3'b010,
    OP_RSVD  = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_REM   = 3'b110,
    OP_REMU  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring-division datapath on unsigned magnitudes, one quotient bit per step.
// Exposes next-state quotient/remainder so the owner can capture the final
// values on the same edge as the last iteration.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_d_o,
  output logic [XLEN-1:0] rem_d_o
);

  logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
  logic [XLEN:0]   shifted, trial;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    quo_d_o = quo_q;
    rem_d_o = rem_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (step_i) begin
      if (!trial[XLEN]) begin
        rem_d_o = trial[XLEN-1:0];
        quo_d_o = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d_o = shifted[XLEN-1:0];
        quo_d_o = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Operand load on accept, otherwise advance by one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvsr_q <= divisor_i;
    end else begin
      quo_q  <= quo_d_o;
      rem_q  <= rem_d_o;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 32-cycle shift-add multiply and restoring
// divide, with single-cycle paths for divide-by-zero, signed overflow and the
// reserved opcode. Define MULDIV_FAST_MUL_EN to make multiplies single-cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic            neg_hi_q, neg_hi_d;    // negate product / quotient at the end
  logic            neg_rem_q, neg_rem_d;  // negate remainder at the end
  logic [XLEN-1:0] prod_hi_q, prod_hi_d;
  logic [XLEN-1:0] prod_lo_q, prod_lo_d;  // multiplier shifts out as product shifts in
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            div_zero_q, div_zero_d;

  logic            is_div_in, signed_div_in, mul_signed_in, use_signed;
  logic            b_zero, ovf, fast_mul_in, quick;
  logic [XLEN-1:0] a_mag, b_mag, quick_result, iter_result;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] prod_full, prod_fix;
  logic            div_load, div_step;
  logic [XLEN-1:0] quo_next, rem_next;

  // Operand classification for the request on the input buses.
  always_comb begin
    is_div_in     = op[2];
    signed_div_in = op[2] & ~op[0];
    mul_signed_in = (op == OP_MULH);
    use_signed    = signed_div_in | mul_signed_in;
    a_mag         = magnitude(a, use_signed);
    b_mag         = magnitude(b, use_signed);
    b_zero        = (b == '0);
    ovf           = signed_div_in && (a == INT_MIN) && (b == '1);
`ifdef MULDIV_FAST_MUL_EN
    fast_mul_in   = ~op[2] & (op != OP_RSVD);
`else
    fast_mul_in   = 1'b0;
`endif
    quick         = (op == OP_RSVD) | (is_div_in & (b_zero | ovf)) | fast_mul_in;
  end

  // Result for requests that complete without iterating.
  always_comb begin
    quick_result = '0;
    if (is_div_in) begin
      if (b_zero) quick_result = op[1] ? a : DIV_ZERO_Q;
      else        quick_result = op[1] ? '0 : INT_MIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (op != OP_RSVD) begin
      logic signed [XLEN:0]     fast_a, fast_b;
      logic signed [2*XLEN-1:0] fast_prod;
      fast_a    = {(op == OP_MULHU) ? 1'b0 : a[XLEN-1], a};
      fast_b    = {(op == OP_MULHU) ? 1'b0 : b[XLEN-1], b};
      fast_prod = fast_a * fast_b;
      quick_result = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // Shift-add step and end-of-operation sign fix-up from the final step values.
  always_comb begin
    mul_sum   = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
    prod_full = {mul_sum, prod_lo_q[XLEN-1:1]};
    prod_fix  = neg_hi_q ? -prod_full : prod_full;
    unique case (op_q)
      OP_MUL:            iter_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU: iter_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   iter_result = neg_hi_q  ? -quo_next : quo_next;
      OP_REM, OP_REMU:   iter_result = neg_rem_q ? -rem_next : rem_next;
      default:           iter_result = '0;
    endcase
  end

  // FSM next state plus datapath register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_hi_d   = neg_hi_q;
    neg_rem_d  = neg_rem_q;
    prod_hi_d  = prod_hi_q;
    prod_lo_d  = prod_lo_q;
    mcand_d    = mcand_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
    unique case (state_q)
      S_CALC: begin
        prod_hi_d = mul_sum[XLEN:1];
        prod_lo_d = {mul_sum[0], prod_lo_q[XLEN-1:1]};
        div_step  = op_q[2];
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = iter_result;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          op_d       = op_e'(op);
          div_zero_d = is_div_in & b_zero;
          neg_hi_d   = use_signed & (a[XLEN-1] ^ b[XLEN-1]);
          neg_rem_d  = signed_div_in & a[XLEN-1];
          prod_hi_d  = '0;
          prod_lo_d  = b_mag;
          mcand_d    = a_mag;
          div_load   = is_div_in;
          if (quick) begin
            state_d  = S_DONE;
            result_d = quick_result;
            cnt_d    = '0;
          end else begin
            state_d  = S_CALC;
            cnt_d    = 5'd31;
          end
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      neg_hi_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      prod_hi_q  <= '0;
      prod_lo_q  <= '0;
      mcand_q    <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_hi_q   <= neg_hi_d;
      neg_rem_q  <= neg_rem_d;
      prod_hi_q  <= prod_hi_d;
      prod_lo_q  <= prod_lo_d;
      mcand_q    <= mcand_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  muldiv_div_core u_div_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_d_o    (quo_next),
    .rem_d_o    (rem_next)
  );

  assign busy     = (state_q == S_CALC);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: result, div_zero and edges from accept to done.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output int lat);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    logic            ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    ovf = (o == 3'b100 || o == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    z   = o[2] && (y == 32'd0);
    lat = 32;
    r   = 32'd0;
    case (o)
      3'b000: begin up = ux * uy; r = up[31:0]; end
      3'b001: begin sp = sx * sy; r = sp[63:32]; end
      3'b010: begin up = ux * uy; r = up[63:32]; end
      3'b011: begin r = 32'd0; lat = 0; end
      3'b100: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin sp = sx / sy; r = sp[31:0]; end
      end
      3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) r = x;
        else if (ovf) r = 32'd0;
        else begin sp = sx % sy; r = sp[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    if (z || ovf) lat = 0;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2] && o != 3'b011) lat = 0;
`endif
  endtask

  // Issue one operation; returns at the cycle done is seen (DUT still in DONE).
  // glitch_at >= 0 pulses start with other operands that many edges into CALC.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int glitch_at, output logic [31:0] er,
                        output logic ez);
    int edges, el;
    model(o, x, y, er, ez, el);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, el != 0});
    edges = 0;
    while (!done && edges < 40) begin
      if (edges == glitch_at) begin
        op = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
    end
    check({tag, ".latency"}, edges, el);
    check({tag, ".result"}, result, er);
    check({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, ez});
  endtask

  initial begin
    logic [31:0] er, rv;
    logic        ez;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          pulses;

    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases.
    run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, -1, er, ez);
    @(posedge clk); #1;
    check("hold.done", {31'd0, done}, 32'd0);
    check("hold.result", result, er);
    run_op("mulhu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, er, ez);
    run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, er, ez);
    run_op("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, -1, er, ez);
    run_op("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, -1, er, ez);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, -1, er, ez);
    run_op("divu_5_0", 3'b101, 32'd5, 32'd0, -1, er, ez);
    @(posedge clk); #1;
    check("hold.div_zero", {31'd0, div_zero}, 32'd1);
    run_op("remu_5_0", 3'b111, 32'd5, 32'd0, -1, er, ez);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, er, ez);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1, er, ez);
    run_op("rsvd", 3'b011, 32'h1234_5678, 32'd9, -1, er, ez);
    run_op("glitch_divu", 3'b101, 32'd100, 32'd7, 5, er, ez);
    // Back-to-back: second request accepted while the first sits in DONE.
    run_op("b2b_first", 3'b100, 32'd1000, 32'hFFFF_FFF6, -1, er, ez);
    run_op("b2b_second", 3'b111, 32'd1000, 32'd33, -1, er, ez);

    // Reset at CALC cycle 10 aborts with no done.
    @(posedge clk); #1;
    op = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.result", result, 32'd0);
    @(negedge clk) reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort.no_done", pulses, 32'd0);

    // Randomized operations, with forced corner operands and varied gaps.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
        3: rb = 32'($signed(-$urandom_range(1, 50)));
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, -1, er, ez);
      rv = er;
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          check($sformatf("rand%0d.hold", i), result, rv);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
